// File: rtl/actuator_channel_sequencer.sv
// actuator_channel_sequencer
// NUM_CH independent pulse-train channels behind one shared command port.
// Each accepted command produces cmd_rep+1 pulses of max(cmd_on,1) active
// cycles followed by cmd_off inactive cycles on the selected channel.
// Optional build macro: ACT_PAIR_INTERLOCK_EN -- channels 2i/2i+1 form an
// H-bridge pair and a channel refuses commands while its partner is busy.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | channel quiet, drive at idle level, ready for a command
// ST_ON   | active phase, drive = pol, cnt counts down to 0
// ST_OFF  | inactive phase, drive = ~pol, cnt counts down to 0
module actuator_channel_sequencer #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              user_clock2,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CNT_W-1:0]  cmd_on,
    input  logic [CNT_W-1:0]  cmd_off,
    input  logic [REP_W-1:0]  cmd_rep,
    input  logic              cmd_pol,
    input  logic [NUM_CH-1:0] abort,
    output logic [NUM_CH-1:0] drive,
    output logic [NUM_CH-1:0] drive_oeb,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] on_q    [NUM_CH];
    logic [CNT_W-1:0] on_d    [NUM_CH];
    logic [CNT_W-1:0] off_q   [NUM_CH];
    logic [CNT_W-1:0] off_d   [NUM_CH];
    logic [REP_W-1:0] rep_q   [NUM_CH];
    logic [REP_W-1:0] rep_d   [NUM_CH];

    logic [NUM_CH-1:0] pol_q, pol_d;
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [NUM_CH-1:0] oeb_q, oeb_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              irq_q, irq_d;

    logic [NUM_CH-1:0] partner_busy;
    logic [NUM_CH-1:0] accept;

    // ON length of zero is stretched to one cycle; the counter holds length-1
    // so a full-scale count still fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] on_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

`ifdef ACT_PAIR_INTERLOCK_EN
    // Partner of channel g is g^1; an odd trailing channel has no partner.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pair
        if ((g ^ 1) < NUM_CH) begin : g_paired
            assign partner_busy[g] = busy[g ^ 1];
        end else begin : g_single
            assign partner_busy[g] = 1'b0;
        end
    end
`else
    assign partner_busy = '0;
`endif

    // Command handshake: out-of-range channel indices never match any channel.
    always_comb begin
        cmd_ready = 1'b0;
        accept    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
                cmd_ready = ~busy[i] & ~abort[i] & ~partner_busy[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i] = cmd_valid & cmd_ready & (cmd_ch == CH_W'(i));
        end
    end

    // State register: per-channel FSM, counters and latched command fields.
    always_ff @(posedge user_clock2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                on_q[i]    <= '0;
                off_q[i]   <= '0;
                rep_q[i]   <= '0;
            end
            pol_q  <= '0;
            seen_q <= '0;
            oeb_q  <= '1;
            done_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            off_q   <= off_d;
            rep_q   <= rep_d;
            pol_q   <= pol_d;
            seen_q  <= seen_d;
            oeb_q   <= oeb_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    // Next-state logic: abort has priority over phase progression.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        off_d   = off_q;
        rep_d   = rep_q;
        pol_d   = pol_q;
        seen_d  = seen_q;
        oeb_d   = oeb_q;
        done_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (accept[i]) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = on_load(cmd_on);
                        on_d[i]    = cmd_on;
                        off_d[i]   = cmd_off;
                        rep_d[i]   = cmd_rep;
                        pol_d[i]   = cmd_pol;
                        seen_d[i]  = 1'b1;
                        oeb_d[i]   = 1'b0;
                    end
                end
                ST_ON: begin
                    if (abort[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else if (off_q[i] != '0) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = off_q[i] - CNT_W'(1);
                    end else if (rep_q[i] != '0) begin
                        rep_d[i] = rep_q[i] - REP_W'(1);
                        cnt_d[i] = on_load(on_q[i]);
                    end else begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (abort[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else if (rep_q[i] != '0) begin
                        state_d[i] = ST_ON;
                        rep_d[i]   = rep_q[i] - REP_W'(1);
                        cnt_d[i]   = on_load(on_q[i]);
                    end else begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        irq_d = |done_d;
    end

    // Outputs: drive follows phase; an idle channel rests at ~pol once commanded.
    always_comb begin
        busy  = '0;
        drive = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (state_q[i] != ST_IDLE);
            case (state_q[i])
                ST_ON:   drive[i] = pol_q[i];
                ST_OFF:  drive[i] = ~pol_q[i];
                default: drive[i] = seen_q[i] & ~pol_q[i];
            endcase
        end
    end

    assign drive_oeb = oeb_q;
    assign done      = done_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_actuator_channel_sequencer.sv
// Testbench for actuator_channel_sequencer: directed scenarios plus random
// traffic, checked against a pulse-timeline reference model.
module tb_actuator_channel_sequencer;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;
    localparam int REP_W  = 8;
    localparam int CH_W   = 3;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [CNT_W-1:0]  cmd_on;
    logic [CNT_W-1:0]  cmd_off;
    logic [REP_W-1:0]  cmd_rep;
    logic              cmd_pol;
    logic [NUM_CH-1:0] abort;
    logic [NUM_CH-1:0] drive;
    logic [NUM_CH-1:0] drive_oeb;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic              irq;

    int checks = 0;
    int errors = 0;

    actuator_channel_sequencer #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .user_clock2(clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_on     (cmd_on),
        .cmd_off    (cmd_off),
        .cmd_rep    (cmd_rep),
        .cmd_pol    (cmd_pol),
        .abort      (abort),
        .drive      (drive),
        .drive_oeb  (drive_oeb),
        .busy       (busy),
        .done       (done),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each active channel is a position k within a timeline
    // of (rep+1) periods of (max(on,1)+off) cycles.
    bit m_act  [NUM_CH];
    int m_k    [NUM_CH];
    int m_onl  [NUM_CH];
    int m_off  [NUM_CH];
    int m_rep  [NUM_CH];
    bit m_pol  [NUM_CH];
    bit m_seen [NUM_CH];
    bit m_oeb  [NUM_CH];
    bit m_done [NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_act[i] = 0; m_k[i] = 0; m_onl[i] = 1; m_off[i] = 0; m_rep[i] = 0;
            m_pol[i] = 0; m_seen[i] = 0; m_oeb[i] = 1; m_done[i] = 0;
        end
    endtask

    function automatic bit model_ready(input int ch, input logic [NUM_CH-1:0] ab);
        if (ch >= NUM_CH) return 0;
        if (m_act[ch] || ab[ch]) return 0;
`ifdef ACT_PAIR_INTERLOCK_EN
        if ((ch ^ 1) < NUM_CH && m_act[ch ^ 1]) return 0;
`endif
        return 1;
    endfunction

    function automatic bit model_drive(input int i);
        if (m_act[i])
            return ((m_k[i] % (m_onl[i] + m_off[i])) < m_onl[i]) ? m_pol[i] : !m_pol[i];
        return m_seen[i] ? !m_pol[i] : 1'b0;
    endfunction

    function automatic logic [33:0] exp_vec();
        logic [7:0] d, o, b, dn;
        for (int i = 0; i < NUM_CH; i++) begin
            d[i] = model_drive(i); o[i] = m_oeb[i]; b[i] = m_act[i]; dn[i] = m_done[i];
        end
        return {model_ready(int'(cmd_ch), abort), |dn, dn, b, o, d};
    endfunction

    function automatic logic [33:0] obs();
        return {cmd_ready, irq, done, busy, drive_oeb, drive};
    endfunction

    // Set inputs away from the active edge.
    task automatic apply(input bit v, input int ch, input int on, input int off,
                         input int rep, input bit pol, input logic [NUM_CH-1:0] ab);
        @(negedge clk);
        cmd_valid = v;
        cmd_ch    = CH_W'(ch);
        cmd_on    = CNT_W'(on);
        cmd_off   = CNT_W'(off);
        cmd_rep   = REP_W'(rep);
        cmd_pol   = pol;
        abort     = ab;
        #1;
    endtask

    // Advance one clock and move the model by the same edge.
    task automatic tick();
        bit acc;
        int c;
        c   = int'(cmd_ch);
        acc = cmd_valid && model_ready(c, abort);
        @(posedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            m_done[i] = 0;
            if (m_act[i]) begin
                if (abort[i]) begin
                    m_act[i] = 0;
                end else begin
                    m_k[i]++;
                    if (m_k[i] == (m_rep[i] + 1) * (m_onl[i] + m_off[i])) begin
                        m_act[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end
        end
        if (acc) begin
            m_act[c]  = 1;
            m_k[c]    = 0;
            m_onl[c]  = (cmd_on == 0) ? 1 : int'(cmd_on);
            m_off[c]  = int'(cmd_off);
            m_rep[c]  = int'(cmd_rep);
            m_pol[c]  = cmd_pol;
            m_seen[c] = 1;
            m_oeb[c]  = 0;
        end
    endtask

    task automatic clear_all();
        logic [33:0] ev;
        apply(0, 0, 0, 0, 0, 0, 8'hFF);
        ev = exp_vec();
        checks++;
        if (obs() !== ev) begin errors++; $display("FAIL clear got %h exp %h", obs(), ev); end
        tick();
    endtask

    task automatic test_reset();
        logic [33:0] ev;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_ch = '0; cmd_on = '0; cmd_off = '0; cmd_rep = '0;
        cmd_pol = 0; abort = '0;
        model_reset();
        #23;
        checks++;
        if ({irq, done, busy, drive_oeb, drive} !== {1'b0, 8'h00, 8'h00, 8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL reset_vals got %h exp %h", {irq, done, busy, drive_oeb, drive},
                     {1'b0, 8'h00, 8'h00, 8'hFF, 8'h00});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            apply(0, j, 0, 0, 0, 0, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL reset_idle cyc %0d got %h exp %h", j, obs(), ev); end
            tick();
        end
    endtask

    task automatic test_ch2_pulses();
        logic [33:0] ev;
        logic [9:0]  pat;
        pat = 10'b0011100111;
        apply(1, 2, 3, 2, 1, 1, '0);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ch2_ready got %b exp 1", cmd_ready); end
        tick();
        for (int j = 0; j < 11; j++) begin
            apply(0, 0, 0, 0, 0, 0, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL ch2_model cyc %0d got %h exp %h", j, obs(), ev); end
            checks++;
            if (j < 10) begin
                if ({drive[2], busy[2], done[2], drive_oeb[2]} !== {pat[j], 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL ch2_wave cyc %0d got %b exp %b", j,
                             {drive[2], busy[2], done[2], drive_oeb[2]}, {pat[j], 1'b1, 1'b0, 1'b0});
                end
            end else begin
                if ({busy[2], done[2], irq, drive[2]} !== 4'b0110) begin
                    errors++;
                    $display("FAIL ch2_done got %b exp 0110", {busy[2], done[2], irq, drive[2]});
                end
            end
            tick();
        end
    endtask

    task automatic test_ch0_zero();
        logic [33:0] ev;
        apply(1, 0, 0, 0, 2, 0, '0);
        tick();
        for (int j = 0; j < 5; j++) begin
            apply(j < 3, 0, 7, 7, 0, 1, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL ch0_model cyc %0d got %h exp %h", j, obs(), ev); end
            checks++;
            if (j < 3 && {cmd_ready, drive[0], busy[0]} !== 3'b001) begin
                errors++;
                $display("FAIL ch0_busy cyc %0d got %b exp 001", j, {cmd_ready, drive[0], busy[0]});
            end else if (j == 3 && {done[0], drive[0], busy[0]} !== 3'b110) begin
                errors++;
                $display("FAIL ch0_done got %b exp 110", {done[0], drive[0], busy[0]});
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [33:0] ev;
        apply(1, 5, 100, 0, 0, 0, '0);
        tick();
        for (int j = 1; j < 15; j++) begin
            if (j == 10) apply(1, 5, 3, 0, 0, 1, 8'h20);
            else         apply(0, 0, 0, 0, 0, 0, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL abort_model cyc %0d got %h exp %h", j, obs(), ev); end
            checks++;
            if (j == 10 && cmd_ready !== 1'b0) begin
                errors++; $display("FAIL abort_ready got %b exp 0", cmd_ready);
            end else if (j > 10 && {busy[5], drive[5], done[5], irq} !== 4'b0100) begin
                errors++;
                $display("FAIL abort_idle cyc %0d got %b exp 0100", j, {busy[5], drive[5], done[5], irq});
            end
            tick();
        end
    endtask

    task automatic test_two_ch();
        logic [33:0] ev;
        int irq_cnt;
        irq_cnt = 0;
        apply(1, 1, 4, 3, 1, 1, '0);
        tick();
        apply(1, 6, 2, 1, 2, 0, '0);
        tick();
        for (int j = 0; j < 20; j++) begin
            apply(0, 0, 0, 0, 0, 0, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL two_ch cyc %0d got %h exp %h", j, obs(), ev); end
            if (irq === 1'b1) irq_cnt++;
            tick();
        end
        checks++;
        if (irq_cnt != 2) begin errors++; $display("FAIL two_ch_irqs got %0d exp 2", irq_cnt); end
    endtask

    task automatic test_interlock();
        logic [33:0] ev;
        int waits;
        bit got;
        int exp_waits;
`ifdef ACT_PAIR_INTERLOCK_EN
        exp_waits = 5;
`else
        exp_waits = 0;
`endif
        waits = 0;
        got = 0;
        apply(1, 0, 5, 0, 0, 1, '0);
        tick();
        for (int j = 0; j < 20 && !got; j++) begin
            apply(1, 1, 2, 0, 0, 1, '0);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL interlock_model cyc %0d got %h exp %h", j, obs(), ev); end
            if (cmd_ready === 1'b1) got = 1;
            else waits++;
            tick();
        end
        checks++;
        if (waits != exp_waits) begin errors++; $display("FAIL interlock_wait got %0d exp %0d", waits, exp_waits); end
        for (int j = 0; j < 4; j++) begin
            apply(0, 0, 0, 0, 0, 0, '0);
            tick();
        end
    endtask

    task automatic test_full_scale();
        logic [33:0] ev;
        apply(1, 7, 16'hFFFF, 16'hFFFF, 8'hFF, 1, '0);
        tick();
        for (int j = 0; j < 40; j++) begin
            apply(0, 0, 0, 0, 0, 0, (j == 39) ? 8'h80 : 8'h00);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL full_scale cyc %0d got %h exp %h", j, obs(), ev); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [33:0] ev;
        logic [NUM_CH-1:0] ab;
        for (int j = 0; j < 1500; j++) begin
            ab = '0;
            for (int b = 0; b < NUM_CH; b++) ab[b] = ($urandom_range(63) == 0);
            apply($urandom_range(2) == 0, $urandom_range(NUM_CH - 1), $urandom_range(6),
                  $urandom_range(4), $urandom_range(3), $urandom_range(1), ab);
            ev = exp_vec();
            checks++;
            if (obs() !== ev) begin errors++; $display("FAIL random cyc %0d got %h exp %h", j, obs(), ev); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] ev;
        apply(1, 3, 20, 0, 0, 1, '0);
        tick();
        for (int j = 0; j < 5; j++) begin
            apply(0, 0, 0, 0, 0, 0, '0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({irq, done, busy, drive_oeb, drive} !== {1'b0, 8'h00, 8'h00, 8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h", {irq, done, busy, drive_oeb, drive},
                     {1'b0, 8'h00, 8'h00, 8'hFF, 8'h00});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 3, 0, 0, 0, 0, '0);
        ev = exp_vec();
        checks++;
        if (obs() !== ev) begin errors++; $display("FAIL reset_mid_after got %h exp %h", obs(), ev); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ch2_pulses();
        clear_all();
        test_ch0_zero();
        clear_all();
        test_abort();
        clear_all();
        test_two_ch();
        clear_all();
        test_interlock();
        clear_all();
        test_full_scale();
        clear_all();
        test_random();
        clear_all();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
